// File: rtl/a0_trace_fifo.sv
// a0_trace_fifo: watches the CPU a0 bus, queues each value change in a small
// FIFO and drains it over a valid/ready handshake so slow sinks never stall
// the core.
// Optional build macro A0_TRACE_TIMESTAMP_EN adds a free-running cycle
// counter, stores its value with every entry and exposes it on out_stamp.
module a0_trace_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   a0_in,
    input  logic                    capture_en,
    input  logic                    clr_ovf,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
`ifdef A0_TRACE_TIMESTAMP_EN
    output logic [31:0]             out_stamp,
`endif
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] last_val_q, last_val_d;
    logic                  last_vld_q, last_vld_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic change, pop, full, push_ok, drop;

    // Handshake, change detection and push/drop decisions.
    always_comb begin
        change    = capture_en & (~last_vld_q | (a0_in != last_val_q));
        out_valid = (count_q != '0);
        full      = (count_q == CW'(DEPTH));
        pop       = out_valid & out_ready;
        // A full FIFO still accepts a push when the head leaves in the same
        // cycle; the write lands in the slot being vacated.
        push_ok   = change & (~full | pop);
        drop      = change & full & ~pop;
    end

    // Next-state for pointers, occupancy, overflow flag and last-seen value.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        last_val_d = last_val_q;
        last_vld_d = last_vld_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (clr_ovf) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;

        // last_val follows every change, even one that gets dropped.
        if (change) begin
            last_val_d = a0_in;
            last_vld_d = 1'b1;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            last_val_q <= '0;
            last_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            last_val_q <= last_val_d;
            last_vld_q <= last_vld_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (rst && push_ok) mem_q[wr_ptr_q] <= a0_in;
    end

    // Head of queue, forced to zero while empty.
    always_comb begin
        out_data = out_valid ? mem_q[rd_ptr_q] : '0;
        count    = count_q;
        overflow = ovf_q;
    end

`ifdef A0_TRACE_TIMESTAMP_EN
    logic [31:0] cyc_q;
    logic [31:0] stamp_q [DEPTH];

    // Free-running cycle counter; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) cyc_q <= '0;
        else      cyc_q <= cyc_q + 32'd1;
    end

    // Timestamp storage, written alongside the data entry.
    always_ff @(posedge clk) begin
        if (rst && push_ok) stamp_q[wr_ptr_q] <= cyc_q;
    end

    // Stamp aligned with out_data, zero while empty.
    always_comb begin
        out_stamp = out_valid ? stamp_q[rd_ptr_q] : 32'd0;
    end
`endif

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Directed bench for a0_trace_fifo (DATA_WIDTH=32, DEPTH=8).
module tb_a0_trace_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a0_in;
    logic        capture_en;
    logic        clr_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  count;
    logic        overflow;
`ifdef A0_TRACE_TIMESTAMP_EN
    logic [31:0] out_stamp;
`endif

    int vectors = 0;
    int fails   = 0;
    logic [31:0] popped [$];

    always #5 clk = ~clk;

    a0_trace_fifo #(.DATA_WIDTH(32), .DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .a0_in      (a0_in),
        .capture_en (capture_en),
        .clr_ovf    (clr_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
`ifdef A0_TRACE_TIMESTAMP_EN
        .out_stamp  (out_stamp),
`endif
        .count      (count),
        .overflow   (overflow)
    );

    // Records a pop about to happen, then advances one edge and settles.
    task automatic step();
        if (out_valid && out_ready) popped.push_back(out_data);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pops(input string tag, input logic [31:0] exp [$]);
        check({tag, "_n"}, 32'(popped.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < popped.size(); i++)
            check($sformatf("%s_%0d", tag, i), popped[i], exp[i]);
        popped.delete();
    endtask

    initial begin
        logic [31:0] exp_q [$];

        rst = 1'b0; a0_in = '0; capture_en = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0;
        step(); step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_data",  out_data, 32'd0);
        rst = 1'b1;
        step();
        check("idle_count", 32'(count), 32'd0);

        // First capture after reset pushes even a zero value.
        capture_en = 1'b1; a0_in = 32'd0;
        step();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_data",  out_data, 32'd0);
        check("first_count", 32'(count), 32'd1);
        step();
        check("static_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        check("drain0_valid", 32'(out_valid), 32'd0);
        popped.delete();

        // Repeated values produce no duplicates.
        foreach (exp_q[i]) exp_q.delete();
        a0_in = 32'd5; step();
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data",  out_data, 32'd5);
        step(); step();
        a0_in = 32'd7; step(); step();
        a0_in = 32'd9; step(); step();
        exp_q = '{32'd5, 32'd7, 32'd9};
        check_pops("dedup", exp_q);
        check("dedup_count", 32'(count), 32'd0);

        // Overflow: nine changes into eight slots with the sink stalled.
        out_ready = 1'b0;
        for (int v = 1; v <= 9; v++) begin
            a0_in = 32'(v); step();
        end
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_flag",  32'(overflow), 32'd1);
        check("ovf_head",  out_data, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        check_pops("ovf_drain", exp_q);
        check("ovf_sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Push and pop together while full.
        out_ready = 1'b0;
        for (int v = 0; v < 8; v++) begin
            a0_in = 32'h11 + 32'(v); step();
        end
        check("full_count", 32'(count), 32'd8);
        out_ready = 1'b1; a0_in = 32'hA;
        step();
        check("pp_count", 32'(count), 32'd8);
        check("pp_ovf",   32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) step();
        exp_q = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17, 32'h18, 32'hA};
        check_pops("pp_drain", exp_q);

        // capture_en gating holds last_val.
        out_ready = 1'b0; a0_in = 32'd3; step();
        check("gate_c1", 32'(count), 32'd1);
        capture_en = 1'b0; a0_in = 32'd4; step(); step();
        check("gate_off", 32'(count), 32'd1);
        capture_en = 1'b1; step();
        check("gate_on", 32'(count), 32'd2);
        step();
        check("gate_same", 32'(count), 32'd2);
        out_ready = 1'b1; step(); step();
        exp_q = '{32'd3, 32'd4};
        check_pops("gate_drain", exp_q);

        // Clear and drop in the same cycle: set wins.
        out_ready = 1'b0;
        for (int v = 0; v < 8; v++) begin
            a0_in = 32'h21 + 32'(v); step();
        end
        check("sw_noovf", 32'(overflow), 32'd0);
        a0_in = 32'h29; clr_ovf = 1'b1; step();
        check("sw_set", 32'(overflow), 32'd1);
        check("sw_count", 32'(count), 32'd8);
        step(); clr_ovf = 1'b0;
        check("sw_clr", 32'(overflow), 32'd0);
        a0_in = 32'h2A; step();
        check("sw_reset", 32'(overflow), 32'd1);

        // Reset mid-operation discards everything.
        rst = 1'b0; a0_in = 32'h2B; step();
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_count", 32'(count), 32'd0);
        check("mid_ovf",   32'(overflow), 32'd0);
        check("mid_data",  out_data, 32'd0);
        rst = 1'b1; a0_in = 32'h55; step();
        check("post_valid", 32'(out_valid), 32'd1);
        check("post_data",  out_data, 32'h55);
        check("post_count", 32'(count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/a0_trace_fifo.md
Name: a0_trace_fifo

Overview:
- Downstream consumer of the CPU's `a0` output bus.
- Samples `a0` every cycle and detects value changes. Each change is pushed into a small FIFO and drained over a valid/ready handshake to a testbench monitor or display driver.
- Decouples the single-cycle core from slower sinks without stalling the core.

Parameters:
- DATA_WIDTH, 32, width of `a0` and of each FIFO entry (matches DATA_BUS).
- DEPTH, 8, number of FIFO entries; must be a power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- a0_in  input  DATA_WIDTH  `a0` value from the CPU.
- capture_en  input  1  when 1, change detection and pushes are enabled.
- clr_ovf  input  1  clears the sticky overflow flag.
- out_valid  output  1  FIFO non-empty; `out_data` is valid.
- out_ready  input  1  sink accepts `out_data` this cycle.
- out_data  output  DATA_WIDTH  oldest FIFO entry.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a change was dropped because the FIFO was full.

Behaviour:
- Synchronous, active-low reset. When rst=0 at a rising edge:
  - read/write pointers=0, count=0, out_valid=0, overflow=0;
  - last_val=0, last_vld=0;
  - out_data reads 0 (memory entries need not be cleared; out_data is forced to 0 while empty).
- Change detect (combinational, evaluated at each edge):
  - `change = capture_en & (~last_vld | (a0_in != last_val))`.
- On change:
  - last_val <= a0_in; last_vld <= 1;
  - push requested with data = a0_in.
- last_val updates on every change, even if the push is dropped.
- capture_en=0: no pushes; last_val and last_vld are held. Re-enabling compares against the held last_val.
- First capture after reset always pushes, even when a0_in=0, because last_vld=0.
- pop = out_valid & out_ready.
- Push succeeds if count<DEPTH, or if count==DEPTH and pop is asserted in the same cycle (simultaneous push+pop when full is legal; count stays DEPTH).
- Push while full without pop:
  - data is dropped, overflow <= 1;
  - pointers and count are unchanged.
- Simultaneous push and pop when empty: count 0 -> 1. The pushed data appears on out_data the next cycle; there is no bypass.
- Latency: a0 change sampled at edge N gives out_valid=1 and out_data=value from cycle N+1, provided the FIFO was empty.
- out_data is the combinational read of mem[rd_ptr]. It is stable while out_valid=1 and out_ready=0.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Full/empty are derived from count.
- count update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- overflow:
  - cleared when clr_ovf=1;
  - if clr_ovf and a dropped push occur in the same cycle, set wins (overflow=1).
- Reset mid-operation discards all pending entries. No out_valid is produced in the cycle following reset.

Optional Feature:
- Macro A0_TRACE_TIMESTAMP_EN.
- When defined:
  - adds a 32-bit free-running cycle counter (reset to 0, wraps at 2^32-1 -> 0);
  - each entry additionally stores the counter value at the push edge;
  - new output port `out_stamp` [31:0] is aligned with out_data and reads 0 when empty.
- When undefined: no counter, no out_stamp port; behaviour is otherwise identical.

Test Plan:
- Reset, then hold capture_en=1 with a0_in=0 -> one push. Cycle after the first capture edge: out_valid=1, out_data=0x00000000, count=1.
- a0_in sequence 5,5,5,7,7,9 with out_ready=1 -> exactly three pops with data 5,7,9, in order. A static value produces no duplicates.
- out_ready=0; drive 9 distinct values 1..9 with DEPTH=8 -> count=8, overflow=1. Then draining with out_ready=1 yields 1..8; value 9 is lost.
- FIFO full (8 entries), out_ready=1 and a new change 0xA in the same cycle -> count stays 8, overflow stays 0, and 0xA appears as the last entry.
- capture_en=0 while a0_in changes 3->4, then capture_en=1 with a0_in=4 and last_val=3 -> one push of 4. capture_en=1 with a0_in equal to last_val -> no push.
- Fill 3 entries, assert rst=0 for one edge, then rst=1 -> out_valid=0, count=0, overflow=0. The next distinct a0_in is captured as the first entry.
